// File: rtl/mem_pkg.sv
// Shared types and defaults for the variable-latency data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned WAIT_W          = 4;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned DEF_DEPTH_LOG2  = 10;
  localparam int unsigned DEF_WAIT_CYCLES = 2;

  // Request captured at acceptance and held for the whole access.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
  } req_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU data-port request/response bundle between the MEM stage and the responder.
interface mem_responder_if;
  import mem_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              we;
  logic              clear;
  logic [DATA_W-1:0] q;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, addr, data, we, clear,
    input  q, busy, done, err
  );

  modport slave (
    input  start, addr, data, we, clear,
    output q, busy, done, err
  );

endinterface

// File: rtl/mem_responder_ram.sv
// Single-port word RAM with synchronous read; read-before-write on a shared address.
module mem_responder_ram #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           d,
  output logic [31:0]           q
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= d;
    q <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Variable-latency responder for the CPU data port: accepts one request, waits
// WAIT_CYCLES, accesses the RAM, then pulses done with registered q/err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  mem
);

  state_e              state, state_nxt;
  logic [WAIT_W-1:0]   cnt;
  req_t                req;
  logic [DATA_W-1:0]   q_r;
  logic                done_r;
  logic                err_r;

  logic                  accept_c;
  logic                  access_c;
  logic                  abort_c;
  logic                  in_range_c;
  logic                  ram_we_c;
  logic [DEPTH_LOG2-1:0] ram_addr_c;
  logic [DATA_W-1:0]     ram_q;
  logic                  unused_addr_lsb_c;

  assign accept_c   = mem.start && (state == IDLE || state == RESP);
  assign access_c   = (state == WAIT) && (cnt == '0);
  // Only reads can be flushed; a write in flight always commits.
  assign abort_c    = (state == WAIT) && mem.clear && !req.we;
  assign in_range_c = (req.addr[ADDR_W-1:DEPTH_LOG2+2] == '0);
  assign ram_we_c   = access_c && req.we && in_range_c;

  // Steer the new address to the RAM on acceptance so data is ready even with zero wait states.
  assign ram_addr_c = accept_c ? mem.addr[DEPTH_LOG2+1:2] : req.addr[DEPTH_LOG2+1:2];
  assign unused_addr_lsb_c = ^req.addr[1:0];

  mem_responder_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_c),
    .addr (ram_addr_c),
    .d    (req.data),
    .q    (ram_q)
  );

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (mem.start) state_nxt = WAIT;
      WAIT: begin
        if (abort_c)        state_nxt = IDLE;
        else if (access_c)  state_nxt = RESP;
      end
      RESP: state_nxt = mem.start ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request latch, wait counter and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req    <= '0;
      cnt    <= '0;
      q_r    <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (accept_c) begin
        req <= '{addr: mem.addr, data: mem.data, we: mem.we};
        cnt <= WAIT_W'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - WAIT_W'(1);
      end
      if (access_c && !abort_c) begin
        done_r <= 1'b1;
        err_r  <= !in_range_c;
        if (!req.we) q_r <= in_range_c ? ram_q : '0;
      end
    end
  end

  assign mem.q    = q_r;
  assign mem.done = done_r;
  assign mem.err  = err_r;
  assign mem.busy = (state == WAIT);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with 2, 0 and 5 wait states.
module tb_mem_responder;

  logic clk;
  logic reset;

  logic        start_v [3];
  logic [31:0] addr_v  [3];
  logic [31:0] data_v  [3];
  logic        we_v    [3];
  logic        clear_v [3];
  logic [31:0] q_v     [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        err_v   [3];

  int n_asserts = 0;
  int n_fail    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 2 : (g == 1) ? 0 : 5;
    mem_responder_if bus ();
    assign bus.start = start_v[g];
    assign bus.addr  = addr_v[g];
    assign bus.data  = data_v[g];
    assign bus.we    = we_v[g];
    assign bus.clear = clear_v[g];
    assign q_v[g]    = bus.q;
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign err_v[g]  = bus.err;
    mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
      .clk   (clk),
      .reset (reset),
      .mem   (bus.slave)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; optional clear or stray start one cycle later; observe a fixed window.
  task automatic req(input int k, input logic [31:0] a, input logic [31:0] d, input logic w,
                     input bit clr, input bit poke,
                     output int nbusy, output int ndone, output logic [31:0] qo, output logic eo);
    @(negedge clk);
    start_v[k] = 1'b1; addr_v[k] = a; data_v[k] = d; we_v[k] = w;
    @(negedge clk);
    start_v[k] = 1'b0;
    clear_v[k] = clr;
    if (poke) begin
      start_v[k] = 1'b1; addr_v[k] = 32'h0; data_v[k] = 32'hFFFF_FFFF; we_v[k] = 1'b1;
    end
    nbusy = 0; ndone = 0; qo = 'x; eo = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (busy_v[k]) nbusy++;
      if (done_v[k]) begin
        if (ndone == 0) begin qo = q_v[k]; eo = err_v[k]; end
        ndone++;
      end
      @(negedge clk);
      start_v[k] = 1'b0;
      clear_v[k] = 1'b0;
    end
  endtask

  initial begin
    int          nb, nd;
    logic [31:0] qo;
    logic        eo;

    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; addr_v[k] = '0; data_v[k] = '0; we_v[k] = 1'b0; clear_v[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_q",    q_v[k],           32'h0);
      chk("reset_busy", 32'(busy_v[k]),   32'h0);
      chk("reset_done", 32'(done_v[k]),   32'h0);
      chk("reset_err",  32'(err_v[k]),    32'h0);
    end

    // W=2 write then read
    req(0, 32'h40, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, nb, nd, qo, eo);
    chk("w2_wr_busy", 32'(nb), 32'd3);
    chk("w2_wr_done", 32'(nd), 32'd1);
    chk("w2_wr_err",  32'(eo), 32'd0);
    chk("w2_wr_q",    q_v[0],  32'h0);
    req(0, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, nb, nd, qo, eo);
    req(0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, nb, nd, qo, eo);
    chk("w2_rd_busy", 32'(nb), 32'd3);
    chk("w2_rd_done", 32'(nd), 32'd1);
    chk("w2_rd_q",    qo,      32'hDEAD_BEEF);
    chk("w2_rd_err",  32'(eo), 32'd0);

    // Aborted read keeps q; write ignores clear
    req(0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, nb, nd, qo, eo);
    chk("abort_done", 32'(nd), 32'd0);
    chk("abort_busy", 32'(nb), 32'd1);
    chk("abort_q",    q_v[0],  32'hDEAD_BEEF);
    chk("abort_idle", 32'(busy_v[0]), 32'd0);
    req(0, 32'h40, 32'h0BAD_F00D, 1'b1, 1'b1, 1'b0, nb, nd, qo, eo);
    chk("clrwr_done", 32'(nd), 32'd1);
    chk("clrwr_busy", 32'(nb), 32'd3);

    // Stray start during WAIT is ignored
    req(0, 32'h40, 32'h0, 1'b0, 1'b0, 1'b1, nb, nd, qo, eo);
    chk("poke_done", 32'(nd), 32'd1);
    chk("poke_q",    qo,      32'h0BAD_F00D);
    req(0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, nb, nd, qo, eo);
    chk("poke_nowr", qo,      32'hCAFE_F00D);

    // Out-of-range read and write
    req(0, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 1'b0, nb, nd, qo, eo);
    chk("oor_rd_done", 32'(nd), 32'd1);
    chk("oor_rd_q",    qo,      32'h0);
    chk("oor_rd_err",  32'(eo), 32'd1);
    req(0, 32'h0001_0000, 32'h1234_5678, 1'b1, 1'b0, 1'b0, nb, nd, qo, eo);
    chk("oor_wr_err",  32'(eo), 32'd1);
    chk("oor_wr_q",    q_v[0],  32'h0);
    req(0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, nb, nd, qo, eo);
    chk("oor_wr_drop", qo,      32'hCAFE_F00D);
    chk("oor_rd0_err", 32'(eo), 32'd0);

    // W=0 setup, then back-to-back reads
    req(1, 32'h0, 32'h1111_1111, 1'b1, 1'b0, 1'b0, nb, nd, qo, eo);
    chk("w0_busy", 32'(nb), 32'd1);
    chk("w0_done", 32'(nd), 32'd1);
    req(1, 32'h4, 32'h2222_2222, 1'b1, 1'b0, 1'b0, nb, nd, qo, eo);
    @(negedge clk);
    start_v[1] = 1'b1; addr_v[1] = 32'h0; we_v[1] = 1'b0;
    @(negedge clk);
    chk("b2b_busy0", 32'(busy_v[1]), 32'd1);
    chk("b2b_done0", 32'(done_v[1]), 32'd0);
    addr_v[1] = 32'h4;
    @(negedge clk);
    chk("b2b_done1", 32'(done_v[1]), 32'd1);
    chk("b2b_q1",    q_v[1],         32'h1111_1111);
    chk("b2b_busy1", 32'(busy_v[1]), 32'd0);
    @(negedge clk);
    chk("b2b_busy2", 32'(busy_v[1]), 32'd1);
    chk("b2b_done2", 32'(done_v[1]), 32'd0);
    start_v[1] = 1'b0;
    @(negedge clk);
    chk("b2b_done3", 32'(done_v[1]), 32'd1);
    chk("b2b_q3",    q_v[1],         32'h2222_2222);

    // W=5 write, then reset mid-write
    req(2, 32'h80, 32'h55AA_55AA, 1'b1, 1'b0, 1'b0, nb, nd, qo, eo);
    chk("w5_busy", 32'(nb), 32'd6);
    chk("w5_done", 32'(nd), 32'd1);
    @(negedge clk);
    start_v[2] = 1'b1; addr_v[2] = 32'h80; data_v[2] = 32'hFFFF_0000; we_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    chk("rst_pre_busy", 32'(busy_v[2]), 32'd1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_v[2]), 32'd0);
    chk("rst_done", 32'(done_v[2]), 32'd0);
    chk("rst_err",  32'(err_v[2]),  32'd0);
    chk("rst_q",    q_v[0],         32'h0);
    @(negedge clk);
    reset = 1'b1;
    req(2, 32'h80, 32'h0, 1'b0, 1'b0, 1'b0, nb, nd, qo, eo);
    chk("rst_nowr_done", 32'(nd), 32'd1);
    chk("rst_nowr_q",    qo,      32'h55AA_55AA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
